ht_reset_sequencer: RTL and testbench
=====================================

// Module: ht_reset_sequencer
// PURPOSE
//  Staged reset controller. Drives the per-unit reset-flop inputs of the HT
//  personality and releases the units one at a time, in index order.
//  Each unit must handshake (ready) or time out before the next unit is released.
//  Also re-runs the full sequence on a software reset request.
// PARAMETERS
//  N_UNITS      3     number of sequenced units (1..16); unit 0 released first
//  HOLD_CYCLES  16    cycles all resets held after entering ASSERT (>=1)
//  GAP_CYCLES   4     idle cycles between a unit's ready/timeout and next release (>=0)
//  TIMEOUT      1024  max cycles to wait for a unit's ready after its release (>=1)
// PORTS
//  clk             in   1        clock
//  i_reset         in   1        async active-high reset; deassertion internally 2-flop synced
//  i_soft_reset    in   1        1-cycle request: re-run whole sequence
//  i_unit_ready    in   N_UNITS  unit k out of reset and initialised (level)
//  o_unit_reset    out  N_UNITS  reset to unit k's reset flop, active-high, registered
//  o_all_ready     out  1        sequence complete, all units ready, registered
//  o_busy          out  1        sequence in progress (ASSERT/RELEASE/WAIT/GAP)
//  o_timeout       out  N_UNITS  sticky: unit k timed out in the current sequence
//  o_fault         out  1        sticky: a ready dropped while in RUN
// BEHAVIOUR
//  - Reset (i_reset=1 or sync stage still 1): state=ASSERT, o_unit_reset=all 1,
//    o_all_ready=0, o_busy=1, o_timeout=0, o_fault=0, counters=0, k=0.
//  - ASSERT: all resets 1; count HOLD_CYCLES cycles; then -> RELEASE.
//  - RELEASE: clear o_unit_reset[k] (visible next cycle); -> WAIT, timer=0.
//  - WAIT: i_unit_ready[k]=1 -> GAP. Timer reaches TIMEOUT-1 with ready low ->
//    set o_timeout[k], -> GAP. Ready and timeout in same cycle: ready wins, no flag.
//  - GAP: count GAP_CYCLES (0 = pass straight through in one cycle).
//    If k==N_UNITS-1 -> RUN, else k++ -> RELEASE.
//  - RUN: o_busy=0. o_all_ready=1 iff &i_unit_ready (registered, 1-cycle lag).
//    Any ready falling in RUN sets o_fault. No automatic recovery.
//  - i_soft_reset=1 in any state: next cycle state=ASSERT, o_unit_reset=all 1,
//    o_all_ready=0, o_busy=1, k=0, o_timeout and o_fault cleared.
//    Soft reset beats every other transition in the same cycle.
//    Asserted again during ASSERT: restarts the hold count.
//  - Released units stay released until ASSERT. Unreleased units stay in reset.
//  - Ready of a unit not yet released is ignored.
//  - Counters saturate, never wrap. Widths are $clog2 of the parameter, min 1.
//  - Hard reset mid-sequence: immediate async return to reset values.
// STRUCTURE
//  - Package ht_reset_seq_pkg: state enum {ASSERT, RELEASE, WAIT, GAP, RUN};
//    function for counter width.
//  - Sub-module ht_reset_stage_cnt: loadable saturating down-counter with
//    zero flag.
//    - One shared instance does hold, timeout and gap, reloaded on each state entry.
//  - Reset deassert synchroniser stays inline (2 flops, async set).
// TESTING (N_UNITS=3, HOLD=16, GAP=4, TIMEOUT=8)
//  1. Release i_reset; readies go high 2 cycles after each release:
//     resets drop in order 0,1,2; o_all_ready=1; o_timeout=000.
//  2. Unit 1 ready held low: o_unit_reset[1] low 8 cycles, o_timeout=010,
//     unit 2 still released, RUN reached with o_all_ready=0.
//  3. i_soft_reset during WAIT on unit 2: all resets back to 111 next cycle,
//     o_timeout cleared, full sequence repeats.
//  4. Drop i_unit_ready[0] in RUN: o_fault=1 and o_all_ready=0 one cycle later;
//     o_unit_reset stays 000.
//  5. Assert i_reset mid-GAP: outputs at reset values asynchronously;
//     release restarts a 16-cycle hold.
//  6. Ready and timeout in same WAIT cycle: no timeout flag.
//     GAP_CYCLES=0 build: next release one cycle after ready.

Source files
------------

// File: rtl/ht_reset_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ht_reset_seq_pkg
// Purpose  : Shared types and helpers for the HT staged reset sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package ht_reset_seq_pkg;

  // Sequencer phases, in the order a normal bring-up walks through them
  typedef enum logic [2:0] {
    ST_ASSERT  = 3'd0,
    ST_RELEASE = 3'd1,
    ST_WAIT    = 3'd2,
    ST_GAP     = 3'd3,
    ST_RUN     = 3'd4
  } seq_state_e;

  // Bits needed to hold values 0..max_val-1, never less than one bit
  function automatic int cnt_width(input int max_val);
    return ($clog2(max_val) < 1) ? 1 : $clog2(max_val);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ht_reset_stage_cnt.sv
`default_nettype none
// ============================================================================
// Module   : ht_reset_stage_cnt
// Purpose  : Loadable saturating down-counter with zero flag. One instance is
//            shared by the hold, timeout and gap phases of the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module ht_reset_stage_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_cnt;

  // Load has priority; decrement stops at zero instead of wrapping
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/ht_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ht_reset_sequencer
// Purpose  : Staged reset controller. Holds every unit in reset, then releases
//            units one at a time in index order, waiting for each unit's ready
//            (or a timeout) plus an idle gap before the next release. A
//            software request re-runs the whole sequence.
// Revision : 1.0 - initial release
// ============================================================================
module ht_reset_sequencer
  import ht_reset_seq_pkg::*;
#(
  parameter int N_UNITS     = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 4,
  parameter int TIMEOUT     = 1024
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic               i_soft_reset,
  input  logic [N_UNITS-1:0] i_unit_ready,
  output logic [N_UNITS-1:0] o_unit_reset,
  output logic               o_all_ready,
  output logic               o_busy,
  output logic [N_UNITS-1:0] o_timeout,
  output logic               o_fault
);

  // One counter covers all three timed phases, so size it for the longest
  localparam int c_max_a  = (HOLD_CYCLES > TIMEOUT) ? HOLD_CYCLES : TIMEOUT;
  localparam int c_max_ld = (c_max_a > GAP_CYCLES) ? c_max_a : GAP_CYCLES;
  localparam int c_cnt_w  = cnt_width(c_max_ld);
  localparam int c_k_w    = cnt_width(N_UNITS);

  // Counter counts down to zero, so a phase of L cycles loads L-1.
  // A zero gap still spends one cycle in GAP, same as a gap of one.
  localparam logic [c_cnt_w-1:0] c_hold_ld = c_cnt_w'(HOLD_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_wait_ld = c_cnt_w'(TIMEOUT - 1);
  localparam logic [c_cnt_w-1:0] c_gap_ld  =
    c_cnt_w'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam logic [c_k_w-1:0]   c_last_k  = c_k_w'(N_UNITS - 1);

  seq_state_e         r_state;
  logic [c_k_w-1:0]   r_k;
  logic [1:0]         r_sync;
  logic [N_UNITS-1:0] r_unit_reset;
  logic [N_UNITS-1:0] r_timeout;
  logic [N_UNITS-1:0] r_ready_q;
  logic               r_all_ready;
  logic               r_busy;
  logic               r_fault;

  logic               w_sync_rst;
  logic               w_rdy_k;
  logic               w_load;
  logic               w_dec;
  logic [c_cnt_w-1:0] w_load_val;
  logic               w_zero;

  // Reset deassertion synchroniser: set asynchronously, clears over two edges
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], 1'b0};
    end
  end

  assign w_sync_rst = r_sync[1];
  assign w_rdy_k    = i_unit_ready[r_k];

  // Counter control: reload on entry to each timed phase, tick down inside it
  always_comb begin
    w_load     = 1'b0;
    w_dec      = 1'b0;
    w_load_val = c_hold_ld;
    if (w_sync_rst || i_soft_reset) begin
      w_load     = 1'b1;
      w_load_val = c_hold_ld;
    end else begin
      case (r_state)
        ST_ASSERT:  w_dec = 1'b1;
        ST_RELEASE: begin
          w_load     = 1'b1;
          w_load_val = c_wait_ld;
        end
        ST_WAIT: begin
          if (w_rdy_k || w_zero) begin
            w_load     = 1'b1;
            w_load_val = c_gap_ld;
          end else begin
            w_dec = 1'b1;
          end
        end
        ST_GAP:     w_dec = 1'b1;
        default:    w_dec = 1'b0;
      endcase
    end
  end

  ht_reset_stage_cnt #(
    .WIDTH (c_cnt_w)
  ) u_stage_cnt (
    .clk        (clk),
    .i_reset    (i_reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  // Previous-cycle readies, used to spot a ready falling while running
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_ready_q <= '0;
    end else begin
      r_ready_q <= i_unit_ready;
    end
  end

  // Sequencer state machine with registered outputs; soft reset wins over all
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= ST_ASSERT;
      r_k          <= '0;
      r_unit_reset <= '1;
      r_all_ready  <= 1'b0;
      r_busy       <= 1'b1;
      r_timeout    <= '0;
      r_fault      <= 1'b0;
    end else if (w_sync_rst || i_soft_reset) begin
      r_state      <= ST_ASSERT;
      r_k          <= '0;
      r_unit_reset <= '1;
      r_all_ready  <= 1'b0;
      r_busy       <= 1'b1;
      r_timeout    <= '0;
      r_fault      <= 1'b0;
    end else begin
      case (r_state)
        ST_ASSERT: begin
          if (w_zero) r_state <= ST_RELEASE;
        end
        ST_RELEASE: begin
          r_unit_reset[r_k] <= 1'b0;
          r_state           <= ST_WAIT;
        end
        ST_WAIT: begin
          // Ready checked first so a last-cycle ready never raises a timeout
          if (w_rdy_k) begin
            r_state <= ST_GAP;
          end else if (w_zero) begin
            r_timeout[r_k] <= 1'b1;
            r_state        <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (w_zero) begin
            if (r_k == c_last_k) begin
              r_state <= ST_RUN;
              r_busy  <= 1'b0;
            end else begin
              r_k     <= r_k + 1'b1;
              r_state <= ST_RELEASE;
            end
          end
        end
        ST_RUN: begin
          r_all_ready <= &i_unit_ready;
          if (|(r_ready_q & ~i_unit_ready)) r_fault <= 1'b1;
        end
        default: r_state <= ST_ASSERT;
      endcase
    end
  end

  assign o_unit_reset = r_unit_reset;
  assign o_all_ready  = r_all_ready;
  assign o_busy       = r_busy;
  assign o_timeout    = r_timeout;
  assign o_fault      = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_ht_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ht_reset_sequencer
// Purpose  : Self-checking bench for ht_reset_sequencer (N=3, HOLD=16, GAP=4,
//            TIMEOUT=8) plus a GAP_CYCLES=0 instance.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ht_reset_sequencer;

  localparam int N = 3;

  typedef struct {
    int unit;
    int gap;
  } exp_t;

  logic         clk = 1'b0;
  logic         i_reset = 1'b1;
  logic         i_soft_reset = 1'b0;
  logic [N-1:0] r_mask = '1;
  logic [N-1:0] r_manual = '0;
  logic [N-1:0] r_auto = '0;
  logic [N-1:0] g0_ready = '0;
  logic [N-1:0] w_ready;

  logic [N-1:0] o_unit_reset, o_timeout;
  logic         o_all_ready, o_busy, o_fault;
  logic [N-1:0] g0_unit_reset, g0_timeout;
  logic         g0_all_ready, g0_busy, g0_fault;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_rel = 0;
  int   soft_cyc = 0;
  int   dly [N];
  exp_t exp_q [$];
  exp_t mon_e;
  logic [N-1:0] prev_rst = '1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign w_ready = (r_auto & r_mask) | r_manual;

  ht_reset_sequencer #(
    .N_UNITS(N), .HOLD_CYCLES(16), .GAP_CYCLES(4), .TIMEOUT(8)
  ) u_dut (
    .clk(clk), .i_reset(i_reset), .i_soft_reset(i_soft_reset),
    .i_unit_ready(w_ready), .o_unit_reset(o_unit_reset),
    .o_all_ready(o_all_ready), .o_busy(o_busy),
    .o_timeout(o_timeout), .o_fault(o_fault)
  );

  ht_reset_sequencer #(
    .N_UNITS(N), .HOLD_CYCLES(16), .GAP_CYCLES(0), .TIMEOUT(8)
  ) u_dut_g0 (
    .clk(clk), .i_reset(i_reset), .i_soft_reset(i_soft_reset),
    .i_unit_ready(g0_ready), .o_unit_reset(g0_unit_reset),
    .o_all_ready(g0_all_ready), .o_busy(g0_busy),
    .o_timeout(g0_timeout), .o_fault(g0_fault)
  );

  // Unit model: ready rises two cycles after its reset is released
  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (o_unit_reset[k]) begin
        dly[k]    = 0;
        r_auto[k] = 1'b0;
      end else if (dly[k] < 2) begin
        dly[k]++;
        if (dly[k] == 2) r_auto[k] = 1'b1;
      end
    end
  end

  // Scoreboard: every release must match the next expected unit and spacing
  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (prev_rst[k] && !o_unit_reset[k]) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL release_unexpected unit=%0d cyc=%0d required=none", k, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.unit != k || (cyc - last_rel) != mon_e.gap) begin
            failures++;
            $display("FAIL release_order got unit=%0d gap=%0d required unit=%0d gap=%0d",
                     k, cyc - last_rel, mon_e.unit, mon_e.gap);
          end
        end
        last_rel = cyc;
      end
    end
    prev_rst = o_unit_reset;
  end

  task automatic push3(input int g0, input int g1, input int g2);
    exp_q.push_back('{0, g0});
    exp_q.push_back('{1, g1});
    exp_q.push_back('{2, g2});
  endtask

  task automatic do_soft();
    @(negedge clk);
    i_soft_reset = 1'b1;
    last_rel     = cyc;
    soft_cyc     = cyc;
    @(negedge clk);
    i_soft_reset = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!o_busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rel(input int k, input bit g0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ((g0 ? g0_unit_reset[k] : o_unit_reset[k]) == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks += 5;
    if (o_unit_reset !== 3'b111) begin failures++; $display("FAIL rst_unit_reset got=%b required=111", o_unit_reset); end
    if (o_all_ready !== 1'b0) begin failures++; $display("FAIL rst_all_ready got=%b required=0", o_all_ready); end
    if (o_busy !== 1'b1) begin failures++; $display("FAIL rst_busy got=%b required=1", o_busy); end
    if (o_timeout !== 3'b000) begin failures++; $display("FAIL rst_timeout got=%b required=000", o_timeout); end
    if (o_fault !== 1'b0) begin failures++; $display("FAIL rst_fault got=%b required=0", o_fault); end
  endtask

  task automatic test_normal();
    bit ok;
    @(negedge clk);
    i_reset  = 1'b0;
    last_rel = cyc;
    push3(19, 7, 7);
    wait_idle(ok);
    repeat (2) @(negedge clk);
    checks += 5;
    if (!ok) begin failures++; $display("FAIL normal_idle_timeout got=busy required=idle"); end
    if (o_all_ready !== 1'b1) begin failures++; $display("FAIL normal_all_ready got=%b required=1", o_all_ready); end
    if (o_timeout !== 3'b000) begin failures++; $display("FAIL normal_timeout got=%b required=000", o_timeout); end
    if (o_unit_reset !== 3'b000) begin failures++; $display("FAIL normal_unit_reset got=%b required=000", o_unit_reset); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL normal_missing_release got=%0d pending required=0", exp_q.size()); end
  endtask

  task automatic test_timeout();
    bit ok;
    r_mask = 3'b101;
    do_soft();
    push3(18, 7, 13);
    wait_idle(ok);
    repeat (2) @(negedge clk);
    checks += 6;
    if (!ok) begin failures++; $display("FAIL tmo_idle_timeout got=busy required=idle"); end
    if (o_timeout !== 3'b010) begin failures++; $display("FAIL tmo_flags got=%b required=010", o_timeout); end
    if (o_unit_reset !== 3'b000) begin failures++; $display("FAIL tmo_unit_reset got=%b required=000", o_unit_reset); end
    if (o_all_ready !== 1'b0) begin failures++; $display("FAIL tmo_all_ready got=%b required=0", o_all_ready); end
    if (o_fault !== 1'b0) begin failures++; $display("FAIL tmo_fault got=%b required=0", o_fault); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL tmo_missing_release got=%0d pending required=0", exp_q.size()); end
  endtask

  task automatic test_soft_in_wait();
    bit ok;
    r_mask = 3'b010;
    do_soft();
    push3(18, 13, 7);
    wait_rel(2, 1'b0, ok);
    checks += 2;
    if (!ok) begin failures++; $display("FAIL siw_rel2_timeout got=reset required=released"); end
    if (o_timeout !== 3'b001) begin failures++; $display("FAIL siw_pre_timeout got=%b required=001", o_timeout); end
    r_mask = 3'b111;
    do_soft();
    push3(18, 7, 7);
    checks += 3;
    if (o_unit_reset !== 3'b111) begin failures++; $display("FAIL siw_unit_reset got=%b required=111", o_unit_reset); end
    if (o_timeout !== 3'b000) begin failures++; $display("FAIL siw_timeout_clr got=%b required=000", o_timeout); end
    if (o_busy !== 1'b1) begin failures++; $display("FAIL siw_busy got=%b required=1", o_busy); end
    wait_idle(ok);
    repeat (2) @(negedge clk);
    checks += 3;
    if (!ok) begin failures++; $display("FAIL siw_idle_timeout got=busy required=idle"); end
    if (o_all_ready !== 1'b1) begin failures++; $display("FAIL siw_all_ready got=%b required=1", o_all_ready); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL siw_missing_release got=%0d pending required=0", exp_q.size()); end
  endtask

  task automatic test_fault();
    checks++;
    if (o_fault !== 1'b0) begin failures++; $display("FAIL flt_pre got=%b required=0", o_fault); end
    @(negedge clk);
    r_mask = 3'b110;
    @(negedge clk);
    checks += 3;
    if (o_fault !== 1'b1) begin failures++; $display("FAIL flt_set got=%b required=1", o_fault); end
    if (o_all_ready !== 1'b0) begin failures++; $display("FAIL flt_all_ready got=%b required=0", o_all_ready); end
    if (o_unit_reset !== 3'b000) begin failures++; $display("FAIL flt_unit_reset got=%b required=000", o_unit_reset); end
    r_mask = 3'b111;
    repeat (2) @(negedge clk);
    checks++;
    if (o_fault !== 1'b1) begin failures++; $display("FAIL flt_sticky got=%b required=1", o_fault); end
  endtask

  task automatic test_hard_mid_gap();
    bit ok;
    do_soft();
    checks++;
    if (o_fault !== 1'b0) begin failures++; $display("FAIL hmg_fault_clr got=%b required=0", o_fault); end
    exp_q.push_back('{0, 18});
    wait_rel(0, 1'b0, ok);
    repeat (3) @(negedge clk);
    i_reset = 1'b1;
    #1;
    checks += 5;
    if (!ok) begin failures++; $display("FAIL hmg_rel0_timeout got=reset required=released"); end
    if (o_unit_reset !== 3'b111) begin failures++; $display("FAIL hmg_unit_reset got=%b required=111", o_unit_reset); end
    if (o_busy !== 1'b1) begin failures++; $display("FAIL hmg_busy got=%b required=1", o_busy); end
    if (o_all_ready !== 1'b0) begin failures++; $display("FAIL hmg_all_ready got=%b required=0", o_all_ready); end
    if (o_timeout !== 3'b000) begin failures++; $display("FAIL hmg_timeout got=%b required=000", o_timeout); end
    @(negedge clk);
    i_reset  = 1'b0;
    last_rel = cyc;
    push3(19, 7, 7);
    wait_idle(ok);
    checks += 2;
    if (!ok) begin failures++; $display("FAIL hmg_idle_timeout got=busy required=idle"); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL hmg_missing_release got=%0d pending required=0", exp_q.size()); end
  endtask

  task automatic test_ready_wins();
    bit ok;
    r_mask   = 3'b110;
    r_manual = 3'b000;
    do_soft();
    push3(18, 13, 7);
    wait_rel(0, 1'b0, ok);
    repeat (7) @(negedge clk);
    r_manual[0] = 1'b1;
    wait_idle(ok);
    repeat (2) @(negedge clk);
    checks += 4;
    if (!ok) begin failures++; $display("FAIL rw_idle_timeout got=busy required=idle"); end
    if (o_timeout !== 3'b000) begin failures++; $display("FAIL rw_timeout got=%b required=000", o_timeout); end
    if (o_all_ready !== 1'b1) begin failures++; $display("FAIL rw_all_ready got=%b required=1", o_all_ready); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL rw_missing_release got=%0d pending required=0", exp_q.size()); end
  endtask

  task automatic test_gap_zero();
    bit ok;
    int t0;
    r_manual = 3'b000;
    r_mask   = 3'b111;
    g0_ready = 3'b000;
    do_soft();
    push3(18, 7, 7);
    wait_rel(0, 1'b1, ok);
    checks += 2;
    if (!ok) begin failures++; $display("FAIL g0_rel0_timeout got=reset required=released"); end
    if (cyc - soft_cyc != 18) begin failures++; $display("FAIL g0_rel0_lat got=%0d required=18", cyc - soft_cyc); end
    t0       = cyc;
    g0_ready = 3'b111;
    for (int k = 1; k < N; k++) begin
      wait_rel(k, 1'b1, ok);
      checks++;
      if (!ok || (cyc - t0) != 3) begin
        failures++;
        $display("FAIL g0_rel_gap unit=%0d got=%0d required=3", k, cyc - t0);
      end
      t0 = cyc;
    end
    repeat (3) @(negedge clk);
    checks += 3;
    if (g0_busy !== 1'b0) begin failures++; $display("FAIL g0_busy got=%b required=0", g0_busy); end
    if (g0_all_ready !== 1'b1) begin failures++; $display("FAIL g0_all_ready got=%b required=1", g0_all_ready); end
    if (g0_timeout !== 3'b000) begin failures++; $display("FAIL g0_timeout got=%b required=000", g0_timeout); end
    wait_idle(ok);
    checks += 2;
    if (!ok) begin failures++; $display("FAIL g0_main_idle got=busy required=idle"); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL g0_missing_release got=%0d pending required=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_timeout();
    test_soft_in_wait();
    test_fault();
    test_hard_mid_gap();
    test_ready_wins();
    test_gap_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=stalled required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
